// File: rtl/shim_spi_sts_sync.sv
// Status receiver for the SPI->AXI toggle handshake: captures the held
// word, returns the ack toggle, tracks sticky bits, updates and staleness.
module shim_spi_sts_sync #(
  parameter int               WIDTH        = 32,
  parameter int               SYNC_DEPTH   = 2,
  parameter logic [WIDTH-1:0] DOUT_DEFAULT = '0,
  parameter logic [WIDTH-1:0] STICKY_MASK  = '0,
  parameter int               STALE_CYCLES = 1000000
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] din,
  output logic             ack_tgl,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] sticky_flags,
  output logic [15:0]      update_count,
  output logic             stale
);

  localparam int SW =
    (STALE_CYCLES < 1) ? 1 : $clog2(STALE_CYCLES + 1);
  localparam logic [SW-1:0] AGE_MAX = SW'(STALE_CYCLES);

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  if (SYNC_DEPTH < 2) begin : g_bad_depth
    $error("SYNC_DEPTH must be at least 2");
  end

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  req_sync;
  state_t                state_q;
  state_t                state_d;
  logic                  capture;
  logic                  ack_q;
  logic [WIDTH-1:0]      dout_q;
  logic                  valid_q;
  logic [WIDTH-1:0]      sticky_q;
  logic [WIDTH-1:0]      sticky_d;
  logic [15:0]           upd_q;
  logic [SW-1:0]         age_q;
  logic                  stale_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], req_tgl};
    end
  end

  assign req_sync = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // SETTLE gives din one extra cycle before it is sampled.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_sync != ack_q) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ack_q   <= 1'b0;
      dout_q  <= DOUT_DEFAULT;
      valid_q <= 1'b0;
      upd_q   <= '0;
    end else begin
      valid_q <= capture;
      if (capture) begin
        ack_q  <= req_sync;
        dout_q <= din;
        upd_q  <= upd_q + 16'd1;
      end
    end
  end

  // A capture in the same cycle as a clear still sets its bits.
  always_comb begin
    sticky_d = sticky_clr ? '0 : sticky_q;
    if (capture) begin
      sticky_d = sticky_d | (din & STICKY_MASK);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      age_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      if (capture) begin
        age_q <= '0;
      end else if (age_q != AGE_MAX) begin
        age_q <= age_q + 1'b1;
      end
      stale_q <= (age_q == AGE_MAX);
    end
  end

  assign ack_tgl      = ack_q;
  assign dout         = dout_q;
  assign dout_valid   = valid_q;
  assign sticky_flags = sticky_q;
  assign update_count = upd_q;
  assign stale        = stale_q;

endmodule
